// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the line-master state type.
//   BURST_INCR : incrementing burst type
//   SIZE_WORD  : 4-byte beat size
//   RESP_OKAY  : normal-access response code
//   state_e    : line-master FSM states
package axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    StIdle,
    StAr,
    StR,
    StAw,
    StW,
    StB,
    StDone
  } state_e;

endpackage

// File: rtl/axi_line_master.sv
// AXI4 burst master that turns one cache-line request into a single INCR burst.
// A fill reads LINE_WORDS beats into the line buffer. A write-back streams the
// latched line out on W and waits for the B response. One resp_valid pulse reports
// completion, with resp_err set on any non-OKAY response or burst-length anomaly.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   req_valid/req_ready          request handshake (req_ready high only in idle)
//   req_write, req_addr          1 = write-back / 0 = fill, line address
//   req_wdata                    write-back line, word 0 in bits [31:0]
//   resp_valid/rdata/err         one-cycle completion, fill data, error flag
//   ar*/r*/aw*/w*/b*             AXI4 master channels toward the memory slave
module axi_line_master
  import axi_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter logic [3:0]  AXI_ID     = 4'd0
) (
  input  logic                    clk,
  input  logic                    rst,
  // Cache-controller side
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [31:0]             req_addr,
  input  logic [32*LINE_WORDS-1:0] req_wdata,
  output logic                    resp_valid,
  output logic [32*LINE_WORDS-1:0] resp_rdata,
  output logic                    resp_err,
  // AR channel
  output logic                    arvalid,
  input  logic                    arready,
  output logic [31:0]             araddr,
  output logic [3:0]              arid,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  // R channel
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [31:0]             rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic [3:0]              rid,
  // AW channel
  output logic                    awvalid,
  input  logic                    awready,
  output logic [31:0]             awaddr,
  output logic [3:0]              awid,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  // W channel
  output logic                    wvalid,
  input  logic                    wready,
  output logic [31:0]             wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  // B channel
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [1:0]              bresp,
  input  logic [3:0]              bid
);

  localparam int unsigned OFF = $clog2(LINE_WORDS * 4);
  localparam int unsigned CW  = $clog2(LINE_WORDS);
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);

  state_e         state;
  logic [CW-1:0]  cnt;
  logic           err;
  logic           b_seen;
  logic [31:0]    addr_q;
  logic [31:0]    line_q [LINE_WORDS];

  logic [CW-1:0]  cnt_inc;
  logic           last_beat;
  logic           r_beat_err;
  logic           b_new;
  logic           b_new_err;
  logic           unused_inputs;

  assign cnt_inc   = cnt + CW'(1);
  assign last_beat = (cnt == LAST);
  // A beat is bad on a non-OKAY response, or when rlast disagrees with the
  // expected final beat (early rlast, or missing rlast on the last word).
  assign r_beat_err = (rresp != RESP_OKAY) || (rlast != last_beat);
  // Only the first B handshake counts; repeats from a sloppy slave are dropped.
  assign b_new     = bvalid && !b_seen;
  assign b_new_err = b_new && (bresp != RESP_OKAY);

  assign araddr  = addr_q;
  assign awaddr  = addr_q;
  assign arid    = AXI_ID;
  assign awid    = AXI_ID;
  assign arlen   = 8'(LINE_WORDS - 1);
  assign awlen   = 8'(LINE_WORDS - 1);
  assign arsize  = SIZE_WORD;
  assign awsize  = SIZE_WORD;
  assign arburst = BURST_INCR;
  assign awburst = BURST_INCR;
  assign wstrb   = 4'hF;

  for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_rdata
    assign resp_rdata[gi*32 +: 32] = line_q[gi];
  end

  assign unused_inputs = ^{rid, bid, req_addr[OFF-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      wlast      <= 1'b0;
      wdata      <= 32'h0;
      bready     <= 1'b0;
      cnt        <= '0;
      err        <= 1'b0;
      b_seen     <= 1'b0;
      addr_q     <= 32'h0;
      for (int i = 0; i < LINE_WORDS; i++) line_q[i] <= 32'h0;
    end else begin
      unique case (state)
        StIdle: begin
          // Also raises req_ready on the first cycle after reset.
          req_ready <= 1'b1;
          if (req_ready && req_valid) begin
            req_ready <= 1'b0;
            addr_q    <= {req_addr[31:OFF], {OFF{1'b0}}};
            for (int i = 0; i < LINE_WORDS; i++) line_q[i] <= req_wdata[i*32 +: 32];
            if (req_write) begin
              awvalid <= 1'b1;
              state   <= StAw;
            end else begin
              arvalid <= 1'b1;
              state   <= StAr;
            end
          end
        end

        StAr: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= StR;
          end
        end

        StR: begin
          if (rvalid) begin
            line_q[cnt] <= rdata;
            cnt         <= cnt_inc;
            if (r_beat_err) err <= 1'b1;
            if (rlast || last_beat) begin
              rready     <= 1'b0;
              resp_valid <= 1'b1;
              resp_err   <= err || r_beat_err;
              state      <= StDone;
            end
          end
        end

        StAw: begin
          if (awready) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            wdata   <= line_q[0];
            wlast   <= (LINE_WORDS == 1);
            bready  <= 1'b1;
            state   <= StW;
          end
        end

        StW: begin
          if (b_new) begin
            b_seen <= 1'b1;
            if (b_new_err) err <= 1'b1;
          end
          if (wready) begin
            cnt <= cnt_inc;
            if (wlast) begin
              wvalid <= 1'b0;
              wlast  <= 1'b0;
              // A B response on this very cycle counts as already recorded.
              if (b_seen || bvalid) begin
                bready     <= 1'b0;
                resp_valid <= 1'b1;
                resp_err   <= err || b_new_err;
                state      <= StDone;
              end else begin
                state <= StB;
              end
            end else begin
              wdata <= line_q[cnt_inc];
              wlast <= (cnt_inc == LAST);
            end
          end
        end

        StB: begin
          if (bvalid) begin
            b_seen     <= 1'b1;
            bready     <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= err || b_new_err;
            state      <= StDone;
          end
        end

        StDone: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          cnt        <= '0;
          err        <= 1'b0;
          b_seen     <= 1'b0;
          state      <= StIdle;
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_line_master.sv
module tb_axi_line_master;

  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [31:0]   req_addr;
  logic [127:0]  req_wdata;
  logic          resp_valid, resp_err;
  logic [127:0]  resp_rdata;
  logic          arvalid, arready;
  logic [31:0]   araddr;
  logic [3:0]    arid;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          rvalid, rready, rlast;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic [3:0]    rid;
  logic          awvalid, awready;
  logic [31:0]   awaddr;
  logic [3:0]    awid;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          wvalid, wready, wlast;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          bvalid, bready;
  logic [1:0]    bresp;
  logic [3:0]    bid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axi_line_master #(.LINE_WORDS(LW), .AXI_ID(4'd0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid)
  );

  // Offers a request and completes its handshake; leaves time at edge+1.
  task automatic issue_req(input logic wr, input logic [31:0] addr, input logic [127:0] line);
    int n = 0;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = line;
    while (req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_errors++; $display("FAIL req_ready_wait: got %b want 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Read fill: slave returns beats from rline, rlast on beat rlast_at (>=LW: never),
  // SLVERR on beat bad_at, AR held off for ar_delay cycles.
  task automatic do_read(input logic [31:0] addr, input logic [127:0] wline,
                         input logic [127:0] rline, input int rlast_at, input int bad_at,
                         input int ar_delay);
    logic [127:0] exp_line = wline;
    logic         exp_err  = 1'b0;
    int           end_beat = LW - 1;
    logic [31:0]  exp_addr = {addr[31:4], 4'h0};
    // Reference: the burst ends at the first rlast or at word LW-1, whichever comes
    // first; it is clean only when both coincide and every response is OKAY.
    for (int i = 0; i < LW; i++) begin
      exp_line[i*32 +: 32] = rline[i*32 +: 32];
      if (i == bad_at) exp_err = 1'b1;
      if (i == rlast_at || i == LW - 1) begin
        if (!(i == LW - 1 && rlast_at == LW - 1)) exp_err = 1'b1;
        end_beat = i;
        break;
      end
    end
    issue_req(1'b0, addr, wline);
    n_checks++;
    if ({arid, arlen, arsize, arburst} !== {4'd0, 8'd3, 3'b010, 2'b01}) begin
      n_errors++; $display("FAIL ar_fields: got %h want %h", {arid, arlen, arsize, arburst},
                           {4'd0, 8'd3, 3'b010, 2'b01});
    end
    for (int c = 0; c <= ar_delay; c++) begin
      n_checks++;
      if ({arvalid, rready, araddr} !== {1'b1, 1'b0, exp_addr}) begin
        n_errors++; $display("FAIL ar_phase cycle %0d: arvalid=%b rready=%b araddr=%h want 1 0 %h",
                             c, arvalid, rready, araddr, exp_addr);
      end
      arready = (c == ar_delay);
      @(posedge clk); #1;
    end
    arready = 1'b0;
    for (int i = 0; i <= end_beat; i++) begin
      int gap = $urandom_range(0, 1);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
      n_checks++;
      if ({rready, resp_valid} !== 2'b10) begin
        n_errors++; $display("FAIL r_phase beat %0d: rready=%b resp_valid=%b want 1 0",
                             i, rready, resp_valid);
      end
      rvalid = 1'b1; rdata = rline[i*32 +: 32]; rlast = (i == rlast_at);
      rresp = (i == bad_at) ? 2'b10 : 2'b00;
      @(posedge clk); #1;
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    end
    n_checks++;
    if ({resp_valid, resp_err, rready, resp_rdata} !== {1'b1, exp_err, 1'b0, exp_line}) begin
      n_errors++; $display("FAIL read_resp: valid=%b err=%b rready=%b data=%h want 1 %b 0 %h",
                           resp_valid, resp_err, rready, resp_rdata, exp_err, exp_line);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      n_errors++; $display("FAIL read_after: resp_valid=%b req_ready=%b want 0 1",
                           resp_valid, req_ready);
    end
  endtask

  // Write-back. b_mode 0: bvalid with the first wready plus a later bogus pulse;
  // 1: bvalid after the last beat; 2: bvalid together with the last wready.
  task automatic do_write(input logic [31:0] addr, input logic [127:0] line,
                          input logic [1:0] bresp_val, input int b_mode, input int aw_delay);
    logic [31:0] exp_addr = {addr[31:4], 4'h0};
    logic        exp_err  = (bresp_val != 2'b00);
    logic        b_given  = 1'b0;
    logic        spur     = 1'b0;
    logic        wr;
    int          k = 0, stall = 0, guard = 0, wait_b;
    issue_req(1'b1, addr, line);
    n_checks++;
    if ({awid, awlen, awsize, awburst, wstrb} !== {4'd0, 8'd3, 3'b010, 2'b01, 4'hF}) begin
      n_errors++; $display("FAIL aw_fields: got %h want %h", {awid, awlen, awsize, awburst, wstrb},
                           {4'd0, 8'd3, 3'b010, 2'b01, 4'hF});
    end
    for (int c = 0; c <= aw_delay; c++) begin
      n_checks++;
      if ({awvalid, wvalid, awaddr} !== {1'b1, 1'b0, exp_addr}) begin
        n_errors++; $display("FAIL aw_phase cycle %0d: awvalid=%b wvalid=%b awaddr=%h want 1 0 %h",
                             c, awvalid, wvalid, awaddr, exp_addr);
      end
      awready = (c == aw_delay);
      @(posedge clk); #1;
    end
    awready = 1'b0;
    while (k < LW && guard < 60) begin
      guard++;
      n_checks++;
      if ({wvalid, bready, resp_valid} !== 3'b110) begin
        n_errors++; $display("FAIL w_phase beat %0d: wvalid=%b bready=%b resp_valid=%b want 1 1 0",
                             k, wvalid, bready, resp_valid);
      end
      wr = (stall >= 2) || ($urandom_range(0, 2) != 0);
      if (wr) begin
        stall = 0;
        n_checks++;
        if ({wdata, wlast} !== {line[k*32 +: 32], (k == LW - 1)}) begin
          n_errors++; $display("FAIL w_beat %0d: wdata=%h wlast=%b want %h %b",
                               k, wdata, wlast, line[k*32 +: 32], (k == LW - 1));
        end
      end else begin
        stall++;
      end
      bvalid = 1'b0; bresp = 2'b00;
      if (b_mode == 0 && !b_given && wr) begin
        bvalid = 1'b1; bresp = bresp_val; b_given = 1'b1;
      end else if (b_mode == 0 && b_given && !spur) begin
        bvalid = 1'b1; bresp = 2'b11; spur = 1'b1;
      end else if (b_mode == 2 && wr && k == LW - 1) begin
        bvalid = 1'b1; bresp = bresp_val; b_given = 1'b1;
      end
      wready = wr;
      @(posedge clk); #1;
      wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      if (wr) k++;
    end
    if (b_mode == 1) begin
      wait_b = $urandom_range(0, 2);
      for (int c = 0; c <= wait_b; c++) begin
        n_checks++;
        if ({wvalid, bready, resp_valid} !== 3'b010) begin
          n_errors++; $display("FAIL b_phase: wvalid=%b bready=%b resp_valid=%b want 0 1 0",
                               wvalid, bready, resp_valid);
        end
        bvalid = (c == wait_b); bresp = bresp_val;
        @(posedge clk); #1;
      end
      bvalid = 1'b0; bresp = 2'b00;
    end
    n_checks++;
    if ({resp_valid, resp_err, wvalid, bready} !== {1'b1, exp_err, 1'b0, 1'b0}) begin
      n_errors++; $display("FAIL write_resp: valid=%b err=%b wvalid=%b bready=%b want 1 %b 0 0",
                           resp_valid, resp_err, wvalid, bready, exp_err);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      n_errors++; $display("FAIL write_after: resp_valid=%b req_ready=%b want 0 1",
                           resp_valid, req_ready);
    end
  endtask

  task automatic test_reset;
    int n = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({req_ready, resp_valid, resp_err, arvalid, rready, awvalid, wvalid, wlast, bready,
         resp_rdata} !== {9'b0, 128'h0}) begin
      n_errors++; $display("FAIL reset_outputs: got %b_%h want all zero",
                           {req_ready, resp_valid, resp_err, arvalid, rready, awvalid, wvalid,
                            wlast, bready}, resp_rdata);
    end
    rst = 1'b0;
    while (req_ready !== 1'b1 && n < 4) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_release: req_ready=%b want 1", req_ready);
    end
  endtask

  task automatic test_read_basic;
    do_read(32'h8000_0014, {$urandom, $urandom, $urandom, $urandom},
            {32'h44, 32'h33, 32'h22, 32'h11}, 3, -1, 0);
  endtask

  task automatic test_read_anomalies;
    do_read(32'h1234_5678, {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000},
            {$urandom, $urandom, $urandom, $urandom}, 1, -1, 0);
    do_read(32'h0000_0100, {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom}, 9, -1, 1);
    do_read(32'h0000_0200, {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom}, 3, 2, 0);
  endtask

  task automatic test_ar_stall;
    do_read(32'h4000_003C, {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom}, 3, -1, 5);
  endtask

  task automatic test_write;
    do_write(32'h8000_0020, {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA},
             2'b00, 0, 0);
    do_write(32'h8000_0040, {$urandom, $urandom, $urandom, $urandom}, 2'b00, 2, 1);
  endtask

  task automatic test_write_bresp_err;
    do_write(32'h9000_0000, {$urandom, $urandom, $urandom, $urandom}, 2'b10, 1, 0);
    do_write(32'h9000_0010, {$urandom, $urandom, $urandom, $urandom}, 2'b00, 1, 2);
  endtask

  task automatic test_random;
    int rl_opts [6] = '{3, 3, 3, 1, 2, 9};
    logic [1:0] br_opts [4] = '{2'b00, 2'b00, 2'b10, 2'b11};
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_write($urandom, {$urandom, $urandom, $urandom, $urandom},
                 br_opts[$urandom_range(0, 3)], int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 3)));
      end else begin
        do_read($urandom, {$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom}, rl_opts[$urandom_range(0, 5)],
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
                int'($urandom_range(0, 3)));
      end
    end
  endtask

  task automatic test_reset_mid_write;
    int n = 0;
    issue_req(1'b1, 32'hA000_0000, {$urandom, $urandom, $urandom, $urandom});
    awready = 1'b1;
    @(posedge clk); #1;
    awready = 1'b0;
    wready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    wready = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({wvalid, awvalid, resp_valid, bready, req_ready} !== 5'b0) begin
      n_errors++; $display("FAIL reset_mid_write: wvalid=%b awvalid=%b resp_valid=%b bready=%b req_ready=%b want 0",
                           wvalid, awvalid, resp_valid, bready, req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    while (req_ready !== 1'b1 && n < 4) begin @(posedge clk); #1; n++; end
    n_checks++;
    if ({req_ready, wvalid, resp_valid} !== 3'b100) begin
      n_errors++; $display("FAIL reset_recover: req_ready=%b wvalid=%b resp_valid=%b want 1 0 0",
                           req_ready, wvalid, resp_valid);
    end
    do_read(32'hA000_0000, {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom}, 3, -1, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 128'h0;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0; rid = 4'h0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 4'h0;
    test_reset();
    test_read_basic();
    test_read_anomalies();
    test_ar_stall();
    test_write();
    test_write_bresp_err();
    test_random();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
